// File: rtl/bpu_pkg.sv
// rtl/bpu_pkg.sv - shared kind encodings, counter states and BTB entry layout for the branch predictor
package bpu_pkg;

    typedef enum logic [1:0] {
        KIND_COND = 2'b00,
        KIND_JUMP = 2'b01,
        KIND_CALL = 2'b10,
        KIND_RET  = 2'b11
    } bpu_kind_t;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    localparam logic [31:0] PC_INC = 32'h4;

    // Tags are held zero-extended to a fixed width so the struct is parameter-free.
    localparam int TAG_MAX_W = 32;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [31:0]          target;
        bpu_kind_t            kind;
        logic [1:0]           ctr;
    } bpu_entry_t;

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken && ctr != CTR_ST) begin
            nxt = ctr + 2'd1;
        end else if (!taken && ctr != CTR_SNT) begin
            nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bpu_ras.sv
// rtl/bpu_ras.sv - circular return-address stack; a push when full overwrites the oldest entry
module bpu_ras #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic [31:0] push_data,
    input  logic        pop,
    output logic [31:0] top,
    output logic        empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]      stack [DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] top_ptr;
    logic [PTR_W:0]   cnt;

    assign top_ptr = ptr - PTR_W'(1);
    assign top     = stack[top_ptr];
    assign empty   = (cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
            cnt <= '0;
        end else if (push) begin
            stack[ptr] <= push_data;
            ptr        <= ptr + PTR_W'(1);
            if (cnt != (PTR_W+1)'(DEPTH)) begin
                cnt <= cnt + (PTR_W+1)'(1);
            end
        end else if (pop && !empty) begin
            ptr <= top_ptr;
            cnt <= cnt - (PTR_W+1)'(1);
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - direct-mapped BTB with 2-bit counters; optional RAS under BPU_RAS_EN
module branch_predict_unit
    import bpu_pkg::*;
#(
    parameter int BTB_ENTRIES = 16,
    parameter int TAG_W       = 10,
    parameter int RAS_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_pc,
    output logic        pred_valid,
    output logic        pred_taken,
    output logic [31:0] pred_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_target,
    input  logic        upd_taken,
    input  logic [1:0]  upd_kind,
    input  logic        upd_mispredict,
    output logic [31:0] mispredict_cnt
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);

    bpu_entry_t btb [BTB_ENTRIES];

    logic [IDX_W-1:0]     f_idx;
    logic [TAG_MAX_W-1:0] f_tag;
    logic                 f_hit;
    logic                 f_taken;
    logic [31:0]          f_seq;
    logic [31:0]          f_target;
    logic [31:0]          f_next;

    logic [IDX_W-1:0]     u_idx;
    logic [TAG_MAX_W-1:0] u_tag;
    logic                 u_hit;
    bpu_kind_t            u_kind;

    logic                 unused_upd_pc;

    assign f_idx = fetch_pc[IDX_W+1:2];
    assign f_tag = TAG_MAX_W'(fetch_pc[IDX_W+1+TAG_W:IDX_W+2]);
    assign f_hit = btb[f_idx].valid && (btb[f_idx].tag == f_tag);
    assign f_seq = fetch_pc + PC_INC;

    assign f_taken = f_hit && ((btb[f_idx].kind != KIND_COND) || btb[f_idx].ctr[1]);

`ifdef BPU_RAS_EN
    logic        ras_push;
    logic        ras_pop;
    logic [31:0] ras_top;
    logic        ras_empty;

    // Calls push their fall-through; returns take the stack top unless it is empty.
    assign ras_push = fetch_valid && f_hit && (btb[f_idx].kind == KIND_CALL);
    assign ras_pop  = fetch_valid && f_hit && (btb[f_idx].kind == KIND_RET) && !ras_empty;
    assign f_target = ras_pop ? ras_top : btb[f_idx].target;

    bpu_ras #(
        .DEPTH(RAS_DEPTH)
    ) u_ras (
        .clk      (clk),
        .reset    (reset),
        .push     (ras_push),
        .push_data(f_seq),
        .pop      (ras_pop),
        .top      (ras_top),
        .empty    (ras_empty)
    );
`else
    localparam int unused_ras_depth = RAS_DEPTH;

    assign f_target = btb[f_idx].target;
`endif

    assign f_next = f_taken ? f_target : f_seq;

    assign u_idx  = upd_pc[IDX_W+1:2];
    assign u_tag  = TAG_MAX_W'(upd_pc[IDX_W+1+TAG_W:IDX_W+2]);
    assign u_hit  = btb[u_idx].valid && (btb[u_idx].tag == u_tag);
    assign u_kind = bpu_kind_t'(upd_kind);

    assign unused_upd_pc = ^upd_pc;

    // Lookup reads the array before this edge's update lands, giving read-before-write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb[i].valid <= 1'b0;
                btb[i].ctr   <= CTR_WNT;
            end
            pred_valid     <= 1'b0;
            pred_taken     <= 1'b0;
            pred_pc        <= '0;
            mispredict_cnt <= '0;
        end else begin
            pred_valid <= fetch_valid;
            pred_taken <= fetch_valid && f_taken;
            pred_pc    <= f_next;

            if (upd_valid) begin
                if (u_hit) begin
                    btb[u_idx].ctr <= ctr_next(btb[u_idx].ctr, upd_taken);
                    if (upd_taken) begin
                        btb[u_idx].target <= upd_target;
                        btb[u_idx].kind   <= u_kind;
                    end
                end else if (upd_taken) begin
                    btb[u_idx].valid  <= 1'b1;
                    btb[u_idx].tag    <= u_tag;
                    btb[u_idx].target <= upd_target;
                    btb[u_idx].kind   <= u_kind;
                    btb[u_idx].ctr    <= (u_kind == KIND_COND) ? CTR_WT : CTR_ST;
                end
            end

            if (upd_valid && upd_mispredict) begin
                mispredict_cnt <= mispredict_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - scoreboard bench for branch_predict_unit; RAS checks under BPU_RAS_EN
module tb_branch_predict_unit;
    import bpu_pkg::*;

    localparam int BTB = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        pred_valid;
    logic        pred_taken;
    logic [31:0] pred_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic [1:0]  upd_kind;
    logic        upd_mispredict;
    logic [31:0] mispredict_cnt;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [32:0] exp_q [$];
    logic [31:0] mis_model;

    always #5 clk = ~clk;

    branch_predict_unit #(
        .BTB_ENTRIES(BTB),
        .TAG_W      (10),
        .RAS_DEPTH  (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .fetch_valid   (fetch_valid),
        .fetch_pc      (fetch_pc),
        .pred_valid    (pred_valid),
        .pred_taken    (pred_taken),
        .pred_pc       (pred_pc),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_target    (upd_target),
        .upd_taken     (upd_taken),
        .upd_kind      (upd_kind),
        .upd_mispredict(upd_mispredict),
        .mispredict_cnt(mispredict_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (pred_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_pred_valid", {31'b0, pred_valid}, 32'd0);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                check("pred_taken", {31'b0, pred_taken}, {31'b0, e[32]});
                check("pred_pc", pred_pc, e[31:0]);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        fetch_valid    = 1'b0;
        upd_valid      = 1'b0;
        upd_mispredict = 1'b0;
    endtask

    task automatic look(input logic [31:0] pc, input logic et, input logic [31:0] epc);
        fetch_valid = 1'b1;
        fetch_pc    = pc;
        if (!reset) exp_q.push_back({et, epc});
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk,
                       input logic [1:0] kind, input logic mis);
        upd_valid      = 1'b1;
        upd_pc         = pc;
        upd_target     = tgt;
        upd_taken      = tk;
        upd_kind       = kind;
        upd_mispredict = mis;
        if (!reset && mis) mis_model = mis_model + 32'd1;
    endtask

`ifdef BPU_RAS_EN
    logic [31:0] ras_exp [6];
`endif

    initial begin
        reset = 1'b1; fetch_valid = 1'b0; fetch_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_target = '0; upd_taken = 1'b0;
        upd_kind = 2'b00; upd_mispredict = 1'b0; mis_model = '0;
        tick();

        // Traffic during reset must be discarded
        look(32'h1c000000, 1'b0, 32'h0);
        upd(32'h1c000000, 32'h1c00fff0, 1'b1, KIND_JUMP, 1'b1);
        tick();
        check("rst_pred_valid", {31'b0, pred_valid}, 32'd0);
        check("rst_pred_taken", {31'b0, pred_taken}, 32'd0);
        check("rst_pred_pc", pred_pc, 32'd0);
        check("rst_mis_cnt", mispredict_cnt, 32'd0);
        reset = 1'b0;

        look(32'h1c000000, 1'b0, 32'h1c000004); tick();

        // Conditional training up then down
        upd(32'h1c000010, 32'h1c000040, 1'b1, KIND_COND, 1'b1); tick();
        check("mis_cnt_a", mispredict_cnt, mis_model);
        upd(32'h1c000010, 32'h1c000040, 1'b1, KIND_COND, 1'b0); tick();
        look(32'h1c000010, 1'b1, 32'h1c000040); tick();
        upd(32'h1c000010, 32'h0, 1'b0, KIND_COND, 1'b1); tick();
        look(32'h1c000010, 1'b1, 32'h1c000040); tick();
        upd(32'h1c000010, 32'h0, 1'b0, KIND_COND, 1'b0); tick();
        look(32'h1c000010, 1'b0, 32'h1c000014); tick();
        check("mis_cnt_b", mispredict_cnt, mis_model);

        // Same-cycle allocate and lookup: read-before-write
        upd(32'h1c000020, 32'h1c000100, 1'b1, KIND_JUMP, 1'b0);
        look(32'h1c000020, 1'b0, 32'h1c000024); tick();
        look(32'h1c000020, 1'b1, 32'h1c000100); tick();

        // Aliasing eviction
        upd(32'h1c000010 + 32'(4 * BTB), 32'h1c000200, 1'b1, KIND_JUMP, 1'b0); tick();
        look(32'h1c000010, 1'b0, 32'h1c000014); tick();
        look(32'h1c000050, 1'b1, 32'h1c000200); tick();

        // Not-taken miss leaves table alone; not-taken hit keeps kind and target
        upd(32'h1c000060, 32'h1c000300, 1'b0, KIND_COND, 1'b0); tick();
        look(32'h1c000060, 1'b0, 32'h1c000064); tick();
        upd(32'h1c000050, 32'h1c000999, 1'b0, KIND_COND, 1'b0); tick();
        look(32'h1c000050, 1'b1, 32'h1c000200); tick();

`ifdef BPU_RAS_EN
        for (int k = 1; k <= 5; k++) begin
            upd(32'(k) * 32'h100, 32'h2000, 1'b1, KIND_CALL, 1'b0); tick();
            look(32'(k) * 32'h100, 1'b1, 32'h2000); tick();
        end
        upd(32'h1c000030, 32'h1c000abc, 1'b1, KIND_RET, 1'b0); tick();
        ras_exp[0] = 32'h504; ras_exp[1] = 32'h404; ras_exp[2] = 32'h304;
        ras_exp[3] = 32'h204; ras_exp[4] = 32'h1c000abc; ras_exp[5] = 32'h1c000abc;
        for (int r = 0; r < 6; r++) begin
            look(32'h1c000030, 1'b1, ras_exp[r]); tick();
        end
`else
        upd(32'h1c000030, 32'h1c000abc, 1'b1, KIND_RET, 1'b0); tick();
        look(32'h1c000030, 1'b1, 32'h1c000abc); tick();
        upd(32'h100, 32'h2000, 1'b1, KIND_CALL, 1'b0); tick();
        look(32'h100, 1'b1, 32'h2000); tick();
        look(32'h1c000030, 1'b1, 32'h1c000abc); tick();
`endif

        // Mid-stream reset wipes learned state and the counter
        upd(32'h1c000070, 32'h1c000400, 1'b1, KIND_JUMP, 1'b1); tick();
        check("mis_cnt_c", mispredict_cnt, mis_model);
        reset = 1'b1; tick(); reset = 1'b0; mis_model = '0;
        check("rst_mid_mis_cnt", mispredict_cnt, mis_model);
        upd(32'h1c000080, 32'h1c000500, 1'b1, KIND_JUMP, 1'b0); tick();
        look(32'h1c000070, 1'b0, 32'h1c000074); tick();
        look(32'h1c000050, 1'b0, 32'h1c000054); tick();
        look(32'h1c000020, 1'b0, 32'h1c000024); tick();
        look(32'h1c000080, 1'b1, 32'h1c000500); tick();
        check("mis_cnt_d", mispredict_cnt, mis_model);
        upd(32'h1c000090, 32'h0, 1'b0, KIND_COND, 1'b1); tick();
        check("mis_cnt_e", mispredict_cnt, mis_model);

        tick();
        check("lost_preds", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
